// File: rtl/dragonfang_pkg.sv
`default_nettype none
// ============================================================================
// Package     : dragonfang_pkg
// Description : State encoding of the sequential vector divide unit.
// Revision    : 1.0 - initial release
// ============================================================================
package dragonfang_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD   = 3'd1,
        DIVIDE = 3'd2,
        WRITE  = 3'd3,
        DONE   = 3'd4
    } vdiv_state_t;

endpackage
`default_nettype wire

// File: rtl/riscv_v_pkg.sv
`default_nettype none
// ============================================================================
// Package     : riscv_v_pkg
// Description : Shared RISC-V vector types: divide opcodes, element widths.
// Revision    : 1.0 - initial release
// ============================================================================
package riscv_v_pkg;

    localparam int VLEN = 128;

    typedef enum logic [1:0] {
        DIVU = 2'd0,
        DIV  = 2'd1,
        REMU = 2'd2,
        REM  = 2'd3
    } div_op_t;

    typedef enum logic [1:0] {
        SEW8  = 2'd0,
        SEW16 = 2'd1,
        SEW32 = 2'd2,
        SEW64 = 2'd3
    } vsew_t;

    function automatic logic [6:0] sew_bits(input vsew_t sew);
        return 7'd8 << sew;
    endfunction

    function automatic logic [63:0] sew_mask(input vsew_t sew);
        return (sew == SEW64) ? {64{1'b1}} : ((64'd1 << sew_bits(sew)) - 64'd1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/vector_element_divider.sv
`default_nettype none
// ============================================================================
// Module      : vector_element_divider
// Description : Radix-2 restoring divider, 64-bit datapath, SEW iterations.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_element_divider
    import riscv_v_pkg::*;
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        i_start,
    input  logic [63:0] i_dividend,
    input  logic [63:0] i_divisor,
    input  vsew_t       i_sew,
    output logic        o_busy,
    output logic [63:0] o_quotient,
    output logic [63:0] o_remainder
);

    logic [63:0] r_quo;
    logic [63:0] r_rem;
    logic [63:0] r_div;
    logic [5:0]  r_count;
    logic        r_active;

    logic [5:0]  w_msb_idx;
    logic [64:0] w_partial;
    logic [64:0] w_diff;
    logic        w_fits;

    // Partial remainder is SEW+1 bits wide; bit 64 of the difference is the borrow.
    always_comb begin
        w_msb_idx = 6'(sew_bits(i_sew) - 7'd1);
        w_partial = {r_rem, r_quo[w_msb_idx]};
        w_diff    = w_partial - {1'b0, r_div};
        w_fits    = ~w_diff[64];
    end

    // Low on the final iteration cycle so the caller can advance without a bubble.
    assign o_busy      = r_active && (r_count != 6'd0);
    assign o_quotient  = r_quo;
    assign o_remainder = r_rem;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_quo    <= '0;
            r_rem    <= '0;
            r_div    <= '0;
            r_count  <= '0;
            r_active <= 1'b0;
        end else if (i_start) begin
            r_quo    <= i_dividend;
            r_rem    <= '0;
            r_div    <= i_divisor;
            r_count  <= w_msb_idx;
            r_active <= 1'b1;
        end else if (r_active) begin
            r_rem <= w_fits ? w_diff[63:0] : w_partial[63:0];
            r_quo <= {r_quo[62:0], w_fits};
            if (r_count == 6'd0) begin
                r_active <= 1'b0;
            end else begin
                r_count <= r_count - 6'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vector_divide_unit_seq.sv
`default_nettype none
// ============================================================================
// Module      : vector_divide_unit_seq
// Description : Multi-cycle vector vdivu/vdiv/vremu/vrem, one element at a time.
// Revision    : 1.0 - initial release
// ============================================================================
module vector_divide_unit_seq
    import riscv_v_pkg::*;
    import dragonfang_pkg::*;
#(
    parameter int VLEN = riscv_v_pkg::VLEN
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  div_op_t         div_op,
    input  vsew_t           vsew,
    input  logic [VLEN-1:0] vs2,
    input  logic [VLEN-1:0] vs1,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [VLEN-1:0] vd
);

    localparam int c_IW = $clog2(VLEN / 8);
    localparam int c_SW = $clog2(VLEN);

    vdiv_state_t     r_state;
    div_op_t         r_op;
    vsew_t           r_vsew;
    logic [VLEN-1:0] r_vs2;
    logic [VLEN-1:0] r_vs1;
    logic [VLEN-1:0] r_vd;
    logic [c_IW-1:0] r_idx;
    logic            r_out_valid;
    logic            r_q_neg;
    logic            r_r_neg;
    logic            r_special;
    logic [63:0]     r_spec_q;
    logic [63:0]     r_spec_r;

    logic [2:0]      w_log2sew;
    logic [c_SW-1:0] w_shamt;
    logic [c_IW-1:0] w_last_idx;
    logic            w_last;
    logic [63:0]     w_mask;
    logic [5:0]      w_sign_idx;
    logic [63:0]     w_min;
    logic            w_signed;
    logic            w_is_rem;
    logic [63:0]     w_a_raw;
    logic [63:0]     w_b_raw;
    logic            w_a_neg;
    logic            w_b_neg;
    logic [63:0]     w_a_abs;
    logic [63:0]     w_b_abs;
    logic            w_div0;
    logic            w_ovf;
    logic            w_start;
    logic            w_div_busy;
    logic [63:0]     w_div_q;
    logic [63:0]     w_div_r;
    logic [63:0]     w_q_fix;
    logic [63:0]     w_r_fix;
    logic [63:0]     w_res;
    logic [VLEN-1:0] w_ins_mask;
    logic [VLEN-1:0] w_ins_val;

    always_comb begin
        w_log2sew  = 3'(r_vsew) + 3'd3;
        w_shamt    = c_SW'(r_idx) << w_log2sew;
        w_last_idx = c_IW'((VLEN >> w_log2sew) - 1);
        w_last     = (r_idx == w_last_idx);
        w_mask     = sew_mask(r_vsew);
        w_sign_idx = 6'(sew_bits(r_vsew) - 7'd1);
        w_min      = 64'd1 << w_sign_idx;
        w_signed   = (r_op == DIV) || (r_op == REM);
        w_is_rem   = (r_op == REM) || (r_op == REMU);

        w_a_raw    = 64'(r_vs2 >> w_shamt) & w_mask;
        w_b_raw    = 64'(r_vs1 >> w_shamt) & w_mask;
        w_a_neg    = w_signed & w_a_raw[w_sign_idx];
        w_b_neg    = w_signed & w_b_raw[w_sign_idx];
        // Operands are zero above SEW, so negate-then-mask yields the SEW-bit magnitude.
        w_a_abs    = w_a_neg ? ((~w_a_raw + 64'd1) & w_mask) : w_a_raw;
        w_b_abs    = w_b_neg ? ((~w_b_raw + 64'd1) & w_mask) : w_b_raw;

        w_div0     = (w_b_raw == 64'd0);
        w_ovf      = w_signed && (w_a_raw == w_min) && (w_b_raw == w_mask);
        w_start    = (r_state == LOAD) && !w_div0 && !w_ovf;

        w_q_fix    = r_q_neg ? (~w_div_q + 64'd1) : w_div_q;
        w_r_fix    = r_r_neg ? (~w_div_r + 64'd1) : w_div_r;
        if (r_special) begin
            w_res = w_is_rem ? r_spec_r : r_spec_q;
        end else begin
            w_res = w_is_rem ? w_r_fix : w_q_fix;
        end
        w_res      = w_res & w_mask;

        w_ins_mask = VLEN'(w_mask) << w_shamt;
        w_ins_val  = VLEN'(w_res) << w_shamt;
    end

    vector_element_divider u_divider (
        .clock       (clock),
        .reset_n     (reset_n),
        .i_start     (w_start),
        .i_dividend  (w_a_abs),
        .i_divisor   (w_b_abs),
        .i_sew       (r_vsew),
        .o_busy      (w_div_busy),
        .o_quotient  (w_div_q),
        .o_remainder (w_div_r)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_op        <= DIVU;
            r_vsew      <= SEW8;
            r_vs2       <= '0;
            r_vs1       <= '0;
            r_vd        <= '0;
            r_idx       <= '0;
            r_out_valid <= 1'b0;
            r_q_neg     <= 1'b0;
            r_r_neg     <= 1'b0;
            r_special   <= 1'b0;
            r_spec_q    <= '0;
            r_spec_r    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_op    <= div_op;
                        r_vsew  <= vsew;
                        r_vs2   <= vs2;
                        r_vs1   <= vs1;
                        r_idx   <= '0;
                        r_state <= LOAD;
                    end
                end
                LOAD: begin
                    r_q_neg   <= w_a_neg ^ w_b_neg;
                    r_r_neg   <= w_a_neg;
                    r_special <= w_div0 | w_ovf;
                    r_spec_q  <= w_div0 ? w_mask : w_a_raw;
                    r_spec_r  <= w_div0 ? w_a_raw : 64'd0;
                    r_state   <= (w_div0 | w_ovf) ? WRITE : DIVIDE;
                end
                DIVIDE: begin
                    if (!w_div_busy) begin
                        r_state <= WRITE;
                    end
                end
                WRITE: begin
                    r_vd <= (r_vd & ~w_ins_mask) | w_ins_val;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end else begin
                        r_idx   <= r_idx + c_IW'(1);
                        r_state <= LOAD;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == IDLE);
    assign out_valid = r_out_valid;
    assign vd        = r_vd;

endmodule
`default_nettype wire

// File: doc/vector_divide_unit_seq.md
# vector_divide_unit_seq

Multi-cycle RISC-V vector integer divide/remainder unit (vdivu, vdiv, vremu, vrem). Sits beside the single-cycle vector multiplication unit in the execute stage. Division cannot close timing combinationally, so this unit iterates one element at a time through a shared radix-2 restoring divider. A valid/ready handshake on both sides lets the issue logic stall around it.

## Interface
Parameters:
- VLEN: from riscv_v_pkg, no local default; benches use 128. Vector register width in bits.

Ports:
- clock  in  1  single clock; all state updates on its rising edge
- reset_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present
- in_ready  out  1  unit idle and able to accept
- div_op  in  div_op_t (2)  DIVU=0, DIV=1, REMU=2, REM=3
- vsew  in  vsew_t (2)  element width: 0=8, 1=16, 2=32, 3=64 bits
- vs2  in  VLEN  dividend vector
- vs1  in  VLEN  divisor vector
- out_valid  out  1  vd holds a complete result
- out_ready  in  1  consumer takes the result
- vd  out  VLEN  result vector, registered

## Operation
- Accept: a request is accepted in a cycle where in_valid and in_ready are both high. div_op, vsew, vs2 and vs1 are latched on acceptance.
- Element count: N = VLEN/SEW. All N elements are written; there is no masking and no tail handling. Element i occupies bits [i·SEW +: SEW], and i=0 is processed first.
- States:
  - IDLE: in_ready=1. Leaves for LOAD on accept.
  - LOAD:
    - Extracts element i.
    - For DIV/REM, takes absolute values and records the quotient sign (operand signs differ) and the remainder sign (dividend sign).
    - Detects special cases; a special case goes directly to WRITE, otherwise the next state is DIVIDE.
  - DIVIDE: exactly SEW cycles, one quotient bit per cycle, MSB first. The partial remainder is SEW+1 bits.
  - WRITE:
    - Applies sign correction: two's-complement negate of the quotient or remainder when its recorded sign is set.
    - Selects the quotient for DIV/DIVU and the remainder for REM/REMU, then inserts it into the vd accumulator.
    - If i=N−1, goes to DONE; otherwise increments i and goes to LOAD.
  - DONE: out_valid=1. Returns to IDLE when out_ready=1.
- Special cases (RISC-V spec values, apply to every op):
  - Divisor = 0: quotient is all ones; remainder is the dividend, unchanged.
  - Signed overflow (DIV/REM only; dividend = most-negative, divisor = −1): quotient = dividend, remainder = 0.
- Unsigned ops never apply sign correction.
- vd is updated only in WRITE. It holds its value through DONE and IDLE until the next request overwrites it.
- in_valid outside IDLE is ignored. No request is queued.

## Timing
- Reset values: state IDLE, in_ready=1, out_valid=0, vd=0, element index 0.
- Reset mid-operation aborts immediately. The partial result is discarded, vd clears to 0, and a request can be accepted on the first clock edge after deassertion.
- Per-element cost: SEW+2 cycles for a normal element; 2 cycles for a special case.
- Latency: accept at cycle 0; out_valid rises at cycle 1 + Σ(element costs).
  - All-normal case: N·(SEW+2)+1.
  - Example, VLEN=128, SEW=32: 4·34+1 = 137.
- out_valid and vd stay stable while out_ready=0. in_ready remains 0 until the cycle after the DONE→IDLE handshake.
- Back-to-back requests: the minimum gap between the output handshake and the next accept is 1 cycle.
- in_ready is a combinational decode of state; no other input-to-output combinational paths exist.

## Structure
- riscv_v_pkg holds div_op_t and vsew_t, plus a function returning SEW bits from vsew_t.
- dragonfang_pkg holds the divider state enum, vdiv_state_t (IDLE, LOAD, DIVIDE, WRITE, DONE).
- Sub-module vector_element_divider (64-bit datapath, width-selected by vsew):
  - Interface: start, unsigned operands, sew, busy, quotient, remainder.
  - Contains the restoring iteration and the bit counter.
- The parent module owns the FSM, element index, sign/special-case logic and the vd accumulator.

## Test plan
All scenarios use VLEN=128.
- DIVU, SEW=32, vs2={100,7,0xFFFFFFFF,9}, vs1={7,7,1,10} (element 0 first) → vd={14,1,0xFFFFFFFF,0}; out_valid exactly at cycle 137.
- SEW=8, elements 0/1 = (−7,2) and (7,−2):
  - DIV → 0xFD (−3), 0xFD (−3).
  - REM → 0xFF (−1), 0x01.
- SEW=16, every divisor = 0, vs2 elements = 0x1234:
  - DIVU → all 0xFFFF; REMU → all 0x1234.
  - out_valid at cycle 8·2+1 = 17.
- SEW=64, element 0 = 0x8000_0000_0000_0000 / 0xFFFF_FFFF_FFFF_FFFF:
  - DIV → 0x8000_0000_0000_0000; REM → 0.
  - Also check DIVU of the same operands → 0.
- Backpressure:
  - Hold out_ready=0 for 10 cycles after out_valid → vd and out_valid stable, in_ready=0.
  - Pulse in_valid during busy with a different vs2 → ignored, result unchanged.
  - Next accept occurs one cycle after the output handshake.
- Assert reset_n=0 mid-DIVIDE of element 2 → out_valid=0, vd=0, in_ready=1 immediately. A fresh DIVU request afterwards completes with correct values and nominal latency.
